// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use and branch-operand hazard detection.
// Optional perf counters (stallCount/flushCount) when HAZARD_PERF_EN is defined.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_ID,
    input  logic [XLEN-1:0] rs1Data_ID,
    input  logic [XLEN-1:0] rs2Data_ID,
    input  logic [XLEN-1:0] imm_ID,
    input  logic [4:0]      rs1_ID,
    input  logic [4:0]      rs2_ID,
    input  logic [4:0]      rd_ID,
    input  logic            useRs1_ID,
    input  logic            useRs2_ID,
    input  logic            bj_ID,
    input  logic            regWrite_ID,
    input  logic            memRead_ID,
    input  logic            memWrite_ID,
    input  logic            memToReg_ID,
    input  logic            aluSrc_ID,
    input  logic [3:0]      aluOp_ID,
    input  logic [4:0]      rd_MEM,
    input  logic            memRead_MEM,
    output logic [XLEN-1:0] pc_EX,
    output logic [XLEN-1:0] rs1Data_EX,
    output logic [XLEN-1:0] rs2Data_EX,
    output logic [XLEN-1:0] imm_EX,
    output logic [4:0]      rs1_EX,
    output logic [4:0]      rs2_EX,
    output logic [4:0]      rd_EX,
    output logic            regWrite_EX,
    output logic            memRead_EX,
    output logic            memWrite_EX,
    output logic            memToReg_EX,
    output logic            aluSrc_EX,
    output logic            valid_EX,
    output logic [3:0]      aluOp_EX,
`ifdef HAZARD_PERF_EN
    output logic [31:0]     stallCount,
    output logic [31:0]     flushCount,
`endif
    output logic            pcWrite,
    output logic            ifidWrite
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            alu_src;
        logic            valid;
        logic [3:0]      alu_op;
    } ex_t;

    ex_t ex_q, ex_d, ex_id;

    logic hit_ex_rs1, hit_ex_rs2, hit_mem_rs1, hit_mem_rs2;
    logic hit_ex, hit_mem;
    logic stall;

    assign hit_ex_rs1  = useRs1_ID && (ex_q.rd != 5'd0) && (ex_q.rd == rs1_ID);
    assign hit_ex_rs2  = useRs2_ID && (ex_q.rd != 5'd0) && (ex_q.rd == rs2_ID);
    assign hit_mem_rs1 = useRs1_ID && (rd_MEM != 5'd0) && (rd_MEM == rs1_ID);
    assign hit_mem_rs2 = useRs2_ID && (rd_MEM != 5'd0) && (rd_MEM == rs2_ID);
    assign hit_ex      = hit_ex_rs1 || hit_ex_rs2;
    assign hit_mem     = hit_mem_rs1 || hit_mem_rs2;

    assign stall = (ex_q.mem_read && hit_ex)
                || (bj_ID && ex_q.reg_write && hit_ex)
                || (bj_ID && memRead_MEM && hit_mem);

    // Flush wins over stall: the front end is being redirected anyway.
    assign pcWrite   = !(hold || (stall && !flush));
    assign ifidWrite = pcWrite;

    always_comb begin
        ex_id            = '0;
        ex_id.pc         = pc_ID;
        ex_id.rs1_data   = rs1Data_ID;
        ex_id.rs2_data   = rs2Data_ID;
        ex_id.imm        = imm_ID;
        ex_id.rs1        = rs1_ID;
        ex_id.rs2        = rs2_ID;
        ex_id.rd         = rd_ID;
        ex_id.reg_write  = regWrite_ID;
        ex_id.mem_read   = memRead_ID;
        ex_id.mem_write  = memWrite_ID;
        ex_id.mem_to_reg = memToReg_ID;
        ex_id.alu_src    = aluSrc_ID;
        ex_id.alu_op     = aluOp_ID;
        ex_id.valid      = 1'b1;
    end

    always_comb begin
        ex_d = ex_q;
        if (hold) begin
            ex_d = ex_q;
        end else if (flush || stall) begin
            ex_d = '0;
        end else begin
            ex_d = ex_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign pc_EX       = ex_q.pc;
    assign rs1Data_EX  = ex_q.rs1_data;
    assign rs2Data_EX  = ex_q.rs2_data;
    assign imm_EX      = ex_q.imm;
    assign rs1_EX      = ex_q.rs1;
    assign rs2_EX      = ex_q.rs2;
    assign rd_EX       = ex_q.rd;
    assign regWrite_EX = ex_q.reg_write;
    assign memRead_EX  = ex_q.mem_read;
    assign memWrite_EX = ex_q.mem_write;
    assign memToReg_EX = ex_q.mem_to_reg;
    assign aluSrc_EX   = ex_q.alu_src;
    assign valid_EX    = ex_q.valid;
    assign aluOp_EX    = ex_q.alu_op;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && !flush && !hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && !hold && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stallCount = stall_cnt_q;
    assign flushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (counter checks only when HAZARD_PERF_EN is defined).
module tb_id_ex_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst, hold, flush;
    logic [XLEN-1:0] pc_ID, rs1Data_ID, rs2Data_ID, imm_ID;
    logic [4:0]      rs1_ID, rs2_ID, rd_ID;
    logic            useRs1_ID, useRs2_ID, bj_ID;
    logic            regWrite_ID, memRead_ID, memWrite_ID, memToReg_ID, aluSrc_ID;
    logic [3:0]      aluOp_ID;
    logic [4:0]      rd_MEM;
    logic            memRead_MEM;
    logic [XLEN-1:0] pc_EX, rs1Data_EX, rs2Data_EX, imm_EX;
    logic [4:0]      rs1_EX, rs2_EX, rd_EX;
    logic            regWrite_EX, memRead_EX, memWrite_EX, memToReg_EX, aluSrc_EX, valid_EX;
    logic [3:0]      aluOp_EX;
    logic            pcWrite, ifidWrite;
`ifdef HAZARD_PERF_EN
    logic [31:0]     stallCount, flushCount;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .pc_ID(pc_ID), .rs1Data_ID(rs1Data_ID), .rs2Data_ID(rs2Data_ID), .imm_ID(imm_ID),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
        .useRs1_ID(useRs1_ID), .useRs2_ID(useRs2_ID), .bj_ID(bj_ID),
        .regWrite_ID(regWrite_ID), .memRead_ID(memRead_ID), .memWrite_ID(memWrite_ID),
        .memToReg_ID(memToReg_ID), .aluSrc_ID(aluSrc_ID), .aluOp_ID(aluOp_ID),
        .rd_MEM(rd_MEM), .memRead_MEM(memRead_MEM),
        .pc_EX(pc_EX), .rs1Data_EX(rs1Data_EX), .rs2Data_EX(rs2Data_EX), .imm_EX(imm_EX),
        .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX),
        .regWrite_EX(regWrite_EX), .memRead_EX(memRead_EX), .memWrite_EX(memWrite_EX),
        .memToReg_EX(memToReg_EX), .aluSrc_EX(aluSrc_EX), .valid_EX(valid_EX),
        .aluOp_EX(aluOp_EX),
`ifdef HAZARD_PERF_EN
        .stallCount(stallCount), .flushCount(flushCount),
`endif
        .pcWrite(pcWrite), .ifidWrite(ifidWrite)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive an ID instruction; datapath operands derived from pc so they are distinct.
    task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic u1, input logic u2, input logic bj,
                          input logic rw, input logic mr);
        pc_ID = pc; rs1Data_ID = pc + 32'h100; rs2Data_ID = pc + 32'h200; imm_ID = pc + 32'h300;
        rs1_ID = rs1; rs2_ID = rs2; rd_ID = rd;
        useRs1_ID = u1; useRs2_ID = u2; bj_ID = bj;
        regWrite_ID = rw; memRead_ID = mr; memWrite_ID = 1'b0; memToReg_ID = mr;
        aluSrc_ID = mr; aluOp_ID = 4'h0;
        #1;
    endtask

    task automatic clear_all();
        hold = 0; flush = 0; rd_MEM = 0; memRead_MEM = 0;
        set_id(32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1;
        clear_all();
        set_id(32'hDEAD_0000, 5'd3, 5'd4, 5'd9, 1, 1, 0, 1, 1);
        tick(); tick();
        rst = 0;
        clear_all();
        tests++; if (valid_EX !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b exp 0", valid_EX); end
        tests++; if ({pc_EX, rs1Data_EX, rs2Data_EX, imm_EX} !== 128'd0) begin fails++; $display("FAIL reset_data got %h exp 0", {pc_EX, rs1Data_EX, rs2Data_EX, imm_EX}); end
        tests++; if ({rs1_EX, rs2_EX, rd_EX, regWrite_EX, memRead_EX, memWrite_EX, memToReg_EX, aluSrc_EX, aluOp_EX} !== 24'd0) begin
            fails++; $display("FAIL reset_ctrl got %h exp 0", {rs1_EX, rs2_EX, rd_EX, regWrite_EX, memRead_EX, memWrite_EX, memToReg_EX, aluSrc_EX, aluOp_EX}); end
        tests++; if ({pcWrite, ifidWrite} !== 2'b11) begin fails++; $display("FAIL reset_pcwrite got %b exp 11", {pcWrite, ifidWrite}); end
    endtask

    task automatic test_load();
        pc_ID = 32'h1234_5678; rs1Data_ID = 32'hAAAA_0001; rs2Data_ID = 32'h5555_0002; imm_ID = 32'hFFFF_FFF0;
        rs1_ID = 5'd11; rs2_ID = 5'd12; rd_ID = 5'd13; useRs1_ID = 1; useRs2_ID = 1; bj_ID = 0;
        regWrite_ID = 1; memRead_ID = 0; memWrite_ID = 1; memToReg_ID = 1; aluSrc_ID = 1; aluOp_ID = 4'hA;
        #1;
        tests++; if (pcWrite !== 1'b1) begin fails++; $display("FAIL load_pcwrite got %b exp 1", pcWrite); end
        tick();
        tests++; if ({pc_EX, rs1Data_EX, rs2Data_EX, imm_EX} !== {32'h1234_5678, 32'hAAAA_0001, 32'h5555_0002, 32'hFFFF_FFF0}) begin
            fails++; $display("FAIL load_data got %h exp 12345678aaaa000155550002fffffff0", {pc_EX, rs1Data_EX, rs2Data_EX, imm_EX}); end
        tests++; if ({rs1_EX, rs2_EX, rd_EX} !== {5'd11, 5'd12, 5'd13}) begin fails++; $display("FAIL load_idx got %h exp %h", {rs1_EX, rs2_EX, rd_EX}, {5'd11, 5'd12, 5'd13}); end
        tests++; if ({regWrite_EX, memRead_EX, memWrite_EX, memToReg_EX, aluSrc_EX, valid_EX, aluOp_EX} !== 10'b10_1111_1010) begin
            fails++; $display("FAIL load_ctrl got %b exp 1011111010", {regWrite_EX, memRead_EX, memWrite_EX, memToReg_EX, aluSrc_EX, valid_EX, aluOp_EX}); end
    endtask

    task automatic test_load_use();
        clear_all();
        set_id(32'h100, 5'd1, 5'd0, 5'd5, 1, 0, 0, 1, 1);   // lw x5
        tick();
        set_id(32'h104, 5'd5, 5'd2, 5'd6, 1, 1, 0, 1, 0);   // add x6, x5, x2
        tests++; if ({pcWrite, ifidWrite} !== 2'b00) begin fails++; $display("FAIL lu_stall got %b exp 00", {pcWrite, ifidWrite}); end
        tick();
        tests++; if ({rd_EX, valid_EX, memRead_EX} !== 7'd0) begin fails++; $display("FAIL lu_bubble got %h exp 0", {rd_EX, valid_EX, memRead_EX}); end
        tests++; if (pcWrite !== 1'b1) begin fails++; $display("FAIL lu_release got %b exp 1", pcWrite); end
        tick();
        tests++; if ({rd_EX, valid_EX, pc_EX} !== {5'd6, 1'b1, 32'h104}) begin fails++; $display("FAIL lu_add got %h exp %h", {rd_EX, valid_EX, pc_EX}, {5'd6, 1'b1, 32'h104}); end
    endtask

    task automatic test_no_stall();
        clear_all();
        set_id(32'h200, 5'd1, 5'd0, 5'd0, 1, 0, 0, 1, 1);   // lw x0
        tick();
        set_id(32'h204, 5'd0, 5'd0, 5'd6, 1, 1, 0, 1, 0);
        tests++; if (pcWrite !== 1'b1) begin fails++; $display("FAIL nostall_x0 got %b exp 1", pcWrite); end
        set_id(32'h208, 5'd1, 5'd0, 5'd5, 1, 0, 0, 1, 1);   // lw x5
        tick();
        set_id(32'h20C, 5'd3, 5'd5, 5'd6, 1, 0, 0, 1, 0);   // rs2 matches but unused
        tests++; if (pcWrite !== 1'b1) begin fails++; $display("FAIL nostall_unused got %b exp 1", pcWrite); end
        set_id(32'h20C, 5'd3, 5'd5, 5'd6, 1, 1, 0, 1, 0);   // now rs2 used
        tests++; if (pcWrite !== 1'b0) begin fails++; $display("FAIL stall_rs2 got %b exp 0", pcWrite); end
        clear_all();
        tick();
    endtask

    task automatic test_branch_after_load();
        clear_all();
        set_id(32'h300, 5'd1, 5'd0, 5'd7, 1, 0, 0, 1, 1);   // lw x7
        tick();
        set_id(32'h304, 5'd7, 5'd1, 5'd0, 1, 1, 1, 0, 0);   // beq x7, x1
        tests++; if (pcWrite !== 1'b0) begin fails++; $display("FAIL bl_stall1 got %b exp 0", pcWrite); end
        tick();
        rd_MEM = 5'd7; memRead_MEM = 1; #1;
        tests++; if ({valid_EX, pcWrite} !== 2'b00) begin fails++; $display("FAIL bl_stall2 got %b exp 00", {valid_EX, pcWrite}); end
        tick();
        rd_MEM = 5'd0; memRead_MEM = 0; #1;
        tests++; if ({valid_EX, pcWrite} !== 2'b01) begin fails++; $display("FAIL bl_release got %b exp 01", {valid_EX, pcWrite}); end
        tick();
        tests++; if ({valid_EX, pc_EX} !== {1'b1, 32'h304}) begin fails++; $display("FAIL bl_beq got %h exp %h", {valid_EX, pc_EX}, {1'b1, 32'h304}); end
    endtask

    task automatic test_branch_after_alu();
        clear_all();
        set_id(32'h400, 5'd1, 5'd0, 5'd7, 1, 0, 0, 1, 0);   // addi x7
        tick();
        set_id(32'h404, 5'd7, 5'd1, 5'd0, 1, 1, 1, 0, 0);   // beq x7, x1
        tests++; if (pcWrite !== 1'b0) begin fails++; $display("FAIL ba_stall got %b exp 0", pcWrite); end
        tick();
        rd_MEM = 5'd7; memRead_MEM = 0; #1;
        tests++; if ({valid_EX, pcWrite} !== 2'b01) begin fails++; $display("FAIL ba_release got %b exp 01", {valid_EX, pcWrite}); end
        tick();
        tests++; if ({valid_EX, pc_EX} !== {1'b1, 32'h404}) begin fails++; $display("FAIL ba_beq got %h exp %h", {valid_EX, pc_EX}, {1'b1, 32'h404}); end
    endtask

    task automatic test_flush();
`ifdef HAZARD_PERF_EN
        logic [31:0] sc0, fc0;
`endif
        clear_all();
        set_id(32'h500, 5'd1, 5'd0, 5'd5, 1, 0, 0, 1, 1);   // lw x5
        tick();
`ifdef HAZARD_PERF_EN
        sc0 = stallCount; fc0 = flushCount;
`endif
        set_id(32'h504, 5'd5, 5'd0, 5'd6, 1, 0, 0, 1, 0);
        flush = 1; #1;
        tests++; if ({pcWrite, ifidWrite} !== 2'b11) begin fails++; $display("FAIL flush_pcwrite got %b exp 11", {pcWrite, ifidWrite}); end
        tick();
        flush = 0; #1;
        tests++; if ({valid_EX, rd_EX, regWrite_EX} !== 7'd0) begin fails++; $display("FAIL flush_bubble got %h exp 0", {valid_EX, rd_EX, regWrite_EX}); end
`ifdef HAZARD_PERF_EN
        tests++; if (flushCount !== fc0 + 32'd1) begin fails++; $display("FAIL flush_count got %0d exp %0d", flushCount, fc0 + 32'd1); end
        tests++; if (stallCount !== sc0) begin fails++; $display("FAIL flush_stallcount got %0d exp %0d", stallCount, sc0); end
`endif
        tick();
    endtask

    task automatic test_hold();
        clear_all();
        set_id(32'h40, 5'd1, 5'd2, 5'd3, 1, 1, 0, 1, 0);
        tick();
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(32'h600 + i, 5'd8, 5'd9, 5'd10, 1, 1, 0, 1, 0);
            tests++; if (pcWrite !== 1'b0) begin fails++; $display("FAIL hold_pcwrite[%0d] got %b exp 0", i, pcWrite); end
            tick();
            tests++; if ({pc_EX, rd_EX, valid_EX} !== {32'h40, 5'd3, 1'b1}) begin fails++; $display("FAIL hold_keep[%0d] got %h exp %h", i, {pc_EX, rd_EX, valid_EX}, {32'h40, 5'd3, 1'b1}); end
        end
        hold = 0; #1;
        tests++; if (pcWrite !== 1'b1) begin fails++; $display("FAIL hold_release got %b exp 1", pcWrite); end
        tick();
        tests++; if ({pc_EX, rd_EX} !== {32'h602, 5'd10}) begin fails++; $display("FAIL hold_resume got %h exp %h", {pc_EX, rd_EX}, {32'h602, 5'd10}); end
    endtask

    task automatic test_hold_in_stall();
        clear_all();
        set_id(32'h700, 5'd1, 5'd0, 5'd5, 1, 0, 0, 1, 1);   // lw x5
        tick();
        set_id(32'h704, 5'd5, 5'd0, 5'd6, 1, 0, 0, 1, 0);
        hold = 1;
        tick(); tick();
        tests++; if ({memRead_EX, rd_EX, pcWrite} !== {1'b1, 5'd5, 1'b0}) begin fails++; $display("FAIL hs_keep got %h exp %h", {memRead_EX, rd_EX, pcWrite}, {1'b1, 5'd5, 1'b0}); end
        hold = 0; #1;
        tests++; if (pcWrite !== 1'b0) begin fails++; $display("FAIL hs_stall got %b exp 0", pcWrite); end
        tick();
        tests++; if ({valid_EX, rd_EX} !== 6'd0) begin fails++; $display("FAIL hs_bubble got %h exp 0", {valid_EX, rd_EX}); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        clear_all();
        set_id(32'h800, 5'd1, 5'd0, 5'd5, 1, 0, 0, 1, 1);   // lw x5
        tick();
        set_id(32'h804, 5'd5, 5'd0, 5'd6, 1, 0, 0, 1, 0);
        rst = 1;
        tick();
        rst = 0; #1;
        tests++; if ({memRead_EX, valid_EX, rd_EX} !== 7'd0) begin fails++; $display("FAIL rms_clear got %h exp 0", {memRead_EX, valid_EX, rd_EX}); end
        tests++; if (pcWrite !== 1'b1) begin fails++; $display("FAIL rms_pcwrite got %b exp 1", pcWrite); end
`ifdef HAZARD_PERF_EN
        tests++; if ({stallCount, flushCount} !== 64'd0) begin fails++; $display("FAIL rms_counts got %h exp 0", {stallCount, flushCount}); end
`endif
    endtask

    initial begin
        rst = 1;
        clear_all();
        test_reset();
        test_load();
        test_load_use();
        test_no_stall();
        test_branch_after_load();
        test_branch_after_alu();
        test_flush();
        test_hold();
        test_hold_in_stall();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
